regfile_access_ctrl: RTL and testbench

Sequences all accesses to the single-command register file, which performs one read-pair or one write per cycle through its op select. Arbitrates between the decode stage (operand reads) and the writeback stage (result writes). Keeps a busy scoreboard so reads stall on pending writes (RAW) and busy destinations (WAW). After reset, runs a clear sequence on the register file before accepting any request.

---
 rtl/regfile_access_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
// Sequences every access to a single-command register file (one read-pair or
// one write per cycle). Writeback requests always win over decode operand
// reads. A busy scoreboard stalls reads on pending writes (RAW) and on busy
// destinations (WAW). After reset the register file is cleared for
// INIT_CYCLES cycles before any request is accepted.
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_dec_*  / o_dec_ready        decode read request (rs1, rs2, rd, set_busy)
//   o_rd_valid, o_rd_rs_1/2       operand response, 2 cycles after acceptance
//   i_wb_*   / o_wb_ready         writeback request (rd, val)
//   o_busy_mask                   scoreboard, bit n = register n pending write
//   o_rf_*                        register file command (clear, op, indices, data)
//   i_rf_rs_1/2                   register file read data (combinational)
module regfile_access_ctrl #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned INIT_CYCLES = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_dec_valid,
    output logic                o_dec_ready,
    input  logic [ADDR_W-1:0]   i_dec_rs1,
    input  logic [ADDR_W-1:0]   i_dec_rs2,
    input  logic [ADDR_W-1:0]   i_dec_rd,
    input  logic                i_dec_set_busy,
    output logic                o_rd_valid,
    output logic [DATA_W-1:0]   o_rd_rs_1,
    output logic [DATA_W-1:0]   o_rd_rs_2,
    input  logic                i_wb_valid,
    output logic                o_wb_ready,
    input  logic [ADDR_W-1:0]   i_wb_rd,
    input  logic [DATA_W-1:0]   i_wb_val,
    output logic [NUM_REGS-1:0] o_busy_mask,
    output logic                o_rf_rst,
    output logic                o_rf_op,
    output logic [ADDR_W-1:0]   o_rf_reg_num_1,
    output logic [ADDR_W-1:0]   o_rf_reg_num_2,
    output logic [ADDR_W-1:0]   o_rf_w_reg_num,
    output logic [DATA_W-1:0]   o_rf_w_val,
    input  logic [DATA_W-1:0]   i_rf_rs_1,
    input  logic [DATA_W-1:0]   i_rf_rs_2
);

    localparam int unsigned CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_RD,
        S_WR
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_rs_1_q, rd_rs_1_d;
    logic [DATA_W-1:0]   rd_rs_2_q, rd_rs_2_d;
    logic                rf_rst_q, rf_rst_d;
    logic                rf_op_q, rf_op_d;
    logic [ADDR_W-1:0]   reg_num_1_q, reg_num_1_d;
    logic [ADDR_W-1:0]   reg_num_2_q, reg_num_2_d;
    logic [ADDR_W-1:0]   w_reg_num_q, w_reg_num_d;
    logic [DATA_W-1:0]   w_val_q, w_val_d;
    logic                hazard;

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            busy_q      <= '0;
            rd_valid_q  <= 1'b0;
            rd_rs_1_q   <= '0;
            rd_rs_2_q   <= '0;
            rf_rst_q    <= 1'b1;
            rf_op_q     <= 1'b0;
            reg_num_1_q <= '0;
            reg_num_2_q <= '0;
            w_reg_num_q <= '0;
            w_val_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            rd_valid_q  <= rd_valid_d;
            rd_rs_1_q   <= rd_rs_1_d;
            rd_rs_2_q   <= rd_rs_2_d;
            rf_rst_q    <= rf_rst_d;
            rf_op_q     <= rf_op_d;
            reg_num_1_q <= reg_num_1_d;
            reg_num_2_q <= reg_num_2_d;
            w_reg_num_q <= w_reg_num_d;
            w_val_q     <= w_val_d;
        end
    end

    // Hazard uses the registered mask, so a write clearing a bit this edge
    // still stalls the dependent read for one cycle.
    always_comb begin
        hazard = busy_q[i_dec_rs1] | busy_q[i_dec_rs2] | (i_dec_set_busy & busy_q[i_dec_rd]);
    end

    // Next-state, arbitration and scoreboard update
    always_comb begin
        state_d     = S_IDLE;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        rd_valid_d  = 1'b0;
        rd_rs_1_d   = rd_rs_1_q;
        rd_rs_2_d   = rd_rs_2_q;
        rf_rst_d    = 1'b0;
        rf_op_d     = 1'b0;
        reg_num_1_d = reg_num_1_q;
        reg_num_2_d = reg_num_2_q;
        w_reg_num_d = w_reg_num_q;
        w_val_d     = w_val_q;
        o_dec_ready = 1'b0;
        o_wb_ready  = 1'b0;

        case (state_q)
            S_INIT: begin
                state_d  = S_INIT;
                rf_rst_d = 1'b1;
                if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                    rf_rst_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                o_wb_ready  = 1'b1;
                o_dec_ready = !i_wb_valid && !hazard;

                // Register file read data for the read issued this cycle
                if (state_q == S_RD) begin
                    rd_valid_d = 1'b1;
                    rd_rs_1_d  = (reg_num_1_q == '0) ? '0 : i_rf_rs_1;
                    rd_rs_2_d  = (reg_num_2_q == '0) ? '0 : i_rf_rs_2;
                end

                if (i_wb_valid) begin
                    state_d = S_WR;
                    // Writes to x0 are accepted and discarded
                    if (i_wb_rd != '0) begin
                        rf_op_d             = 1'b1;
                        w_reg_num_d         = i_wb_rd;
                        w_val_d             = i_wb_val;
                        busy_d[i_wb_rd]     = 1'b0;
                    end
                end else if (i_dec_valid && !hazard) begin
                    state_d     = S_RD;
                    reg_num_1_d = i_dec_rs1;
                    reg_num_2_d = i_dec_rs2;
                    if (i_dec_set_busy && (i_dec_rd != '0)) begin
                        busy_d[i_dec_rd] = 1'b1;
                    end
                end
            end
        endcase

        busy_d[0] = 1'b0;
    end

    assign o_busy_mask    = busy_q;
    assign o_rd_valid     = rd_valid_q;
    assign o_rd_rs_1      = rd_rs_1_q;
    assign o_rd_rs_2      = rd_rs_2_q;
    assign o_rf_rst       = rf_rst_q;
    assign o_rf_op        = rf_op_q;
    assign o_rf_reg_num_1 = reg_num_1_q;
    assign o_rf_reg_num_2 = reg_num_2_q;
    assign o_rf_w_reg_num = w_reg_num_q;
    assign o_rf_w_val     = w_val_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed testbench for regfile_access_ctrl with a behavioural register file.
module tb_regfile_access_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_dec_valid;
    logic        o_dec_ready;
    logic [4:0]  i_dec_rs1;
    logic [4:0]  i_dec_rs2;
    logic [4:0]  i_dec_rd;
    logic        i_dec_set_busy;
    logic        o_rd_valid;
    logic [31:0] o_rd_rs_1;
    logic [31:0] o_rd_rs_2;
    logic        i_wb_valid;
    logic        o_wb_ready;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_val;
    logic [31:0] o_busy_mask;
    logic        o_rf_rst;
    logic        o_rf_op;
    logic [4:0]  o_rf_reg_num_1;
    logic [4:0]  o_rf_reg_num_2;
    logic [4:0]  o_rf_w_reg_num;
    logic [31:0] o_rf_w_val;
    logic [31:0] i_rf_rs_1;
    logic [31:0] i_rf_rs_2;

    int errors = 0;
    int checks = 0;

    logic [31:0] rf [32];

    regfile_access_ctrl dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_dec_valid    (i_dec_valid),
        .o_dec_ready    (o_dec_ready),
        .i_dec_rs1      (i_dec_rs1),
        .i_dec_rs2      (i_dec_rs2),
        .i_dec_rd       (i_dec_rd),
        .i_dec_set_busy (i_dec_set_busy),
        .o_rd_valid     (o_rd_valid),
        .o_rd_rs_1      (o_rd_rs_1),
        .o_rd_rs_2      (o_rd_rs_2),
        .i_wb_valid     (i_wb_valid),
        .o_wb_ready     (o_wb_ready),
        .i_wb_rd        (i_wb_rd),
        .i_wb_val       (i_wb_val),
        .o_busy_mask    (o_busy_mask),
        .o_rf_rst       (o_rf_rst),
        .o_rf_op        (o_rf_op),
        .o_rf_reg_num_1 (o_rf_reg_num_1),
        .o_rf_reg_num_2 (o_rf_reg_num_2),
        .o_rf_w_reg_num (o_rf_w_reg_num),
        .o_rf_w_val     (o_rf_w_val),
        .i_rf_rs_1      (i_rf_rs_1),
        .i_rf_rs_2      (i_rf_rs_2)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural single-command register file
    always @(posedge i_clk) begin
        if (o_rf_rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (o_rf_op) begin
            rf[o_rf_w_reg_num] <= o_rf_w_val;
        end
    end
    assign i_rf_rs_1 = rf[o_rf_reg_num_1];
    assign i_rf_rs_2 = rf[o_rf_reg_num_2];

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_dec_valid = 1'b1;
        i_dec_rs1 = 5'd0;
        i_dec_rs2 = 5'd0;
        i_dec_rd = 5'd0;
        i_dec_set_busy = 1'b0;
        i_wb_valid = 1'b0;
        i_wb_rd = 5'd0;
        i_wb_val = 32'h0;

        // Reset state, then release with a decode request already pending
        repeat (3) next_cycle();
        chk("rst_rf_rst", 64'(o_rf_rst), 64'd1);
        chk("rst_busy", 64'(o_busy_mask), 64'd0);
        chk("rst_rd_valid", 64'(o_rd_valid), 64'd0);
        chk("rst_rf_op", 64'(o_rf_op), 64'd0);
        chk("rst_rd_rs_1", 64'(o_rd_rs_1), 64'd0);
        i_rst = 1'b0;
        #2;
        chk("init1_rf_rst", 64'(o_rf_rst), 64'd1);
        chk("init1_dec_ready", 64'(o_dec_ready), 64'd0);
        chk("init1_wb_ready", 64'(o_wb_ready), 64'd0);
        next_cycle();
        #2;
        chk("init2_rf_rst", 64'(o_rf_rst), 64'd1);
        chk("init2_dec_ready", 64'(o_dec_ready), 64'd0);
        next_cycle();
        #2;
        chk("c3_rf_rst", 64'(o_rf_rst), 64'd0);
        chk("c3_dec_ready", 64'(o_dec_ready), 64'd1);
        chk("c3_wb_ready", 64'(o_wb_ready), 64'd1);
        chk("c3_busy", 64'(o_busy_mask), 64'd0);
        next_cycle();
        i_dec_valid = 1'b0;
        chk("first_rd_pending", 64'(o_rd_valid), 64'd0);
        next_cycle();
        chk("first_rd_valid", 64'(o_rd_valid), 64'd1);
        chk("first_rd_rs_1", 64'(o_rd_rs_1), 64'd0);

        // Write x5 then read it back
        i_wb_valid = 1'b1;
        i_wb_rd = 5'd5;
        i_wb_val = 32'hDEADBEEF;
        #2;
        chk("wr5_wb_ready", 64'(o_wb_ready), 64'd1);
        next_cycle();
        i_wb_valid = 1'b0;
        chk("wr5_rf_op", 64'(o_rf_op), 64'd1);
        chk("wr5_w_reg", 64'(o_rf_w_reg_num), 64'd5);
        chk("wr5_w_val", 64'(o_rf_w_val), 64'hDEADBEEF);
        i_dec_valid = 1'b1;
        i_dec_rs1 = 5'd5;
        i_dec_rs2 = 5'd0;
        #2;
        chk("rd5_dec_ready", 64'(o_dec_ready), 64'd1);
        next_cycle();
        i_dec_valid = 1'b0;
        chk("rd5_rf_op", 64'(o_rf_op), 64'd0);
        chk("rd5_idx1", 64'(o_rf_reg_num_1), 64'd5);
        chk("rd5_valid_early", 64'(o_rd_valid), 64'd0);
        next_cycle();
        chk("rd5_valid", 64'(o_rd_valid), 64'd1);
        chk("rd5_rs_1", 64'(o_rd_rs_1), 64'hDEADBEEF);
        chk("rd5_rs_2", 64'(o_rd_rs_2), 64'd0);
        next_cycle();
        chk("rd5_pulse_end", 64'(o_rd_valid), 64'd0);

        // RAW stall on x7 until its writeback
        i_dec_valid = 1'b1;
        i_dec_rs1 = 5'd1;
        i_dec_rs2 = 5'd2;
        i_dec_rd = 5'd7;
        i_dec_set_busy = 1'b1;
        #2;
        chk("sb7_dec_ready", 64'(o_dec_ready), 64'd1);
        next_cycle();
        chk("sb7_busy", 64'(o_busy_mask), 64'h80);
        i_dec_rs1 = 5'd7;
        i_dec_rs2 = 5'd0;
        i_dec_rd = 5'd0;
        i_dec_set_busy = 1'b0;
        #2;
        chk("raw_stall1", 64'(o_dec_ready), 64'd0);
        next_cycle();
        chk("sb7_rd_valid", 64'(o_rd_valid), 64'd1);
        chk("raw_stall2", 64'(o_dec_ready), 64'd0);
        i_wb_valid = 1'b1;
        i_wb_rd = 5'd7;
        i_wb_val = 32'h12;
        #2;
        chk("raw_wb_prio", 64'(o_dec_ready), 64'd0);
        next_cycle();
        i_wb_valid = 1'b0;
        #2;
        chk("raw_busy_clr", 64'(o_busy_mask), 64'd0);
        chk("raw_wr_op", 64'(o_rf_op), 64'd1);
        chk("raw_dec_ready", 64'(o_dec_ready), 64'd1);
        next_cycle();
        i_dec_valid = 1'b0;
        chk("raw_idx1", 64'(o_rf_reg_num_1), 64'd7);
        next_cycle();
        chk("raw_rd_valid", 64'(o_rd_valid), 64'd1);
        chk("raw_rd_rs_1", 64'(o_rd_rs_1), 64'h12);

        // Writeback and decode together for 3 cycles
        i_dec_valid = 1'b1;
        i_dec_rs1 = 5'd3;
        i_dec_rs2 = 5'd4;
        i_wb_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_wb_rd = 5'(10 + i);
            i_wb_val = 32'(100 + i);
            #2;
            chk("both_dec_ready", 64'(o_dec_ready), 64'd0);
            chk("both_wb_ready", 64'(o_wb_ready), 64'd1);
            next_cycle();
            chk("both_rf_op", 64'(o_rf_op), 64'd1);
            chk("both_w_reg", 64'(o_rf_w_reg_num), 64'(10 + i));
        end
        i_wb_valid = 1'b0;
        #2;
        chk("both_dec_release", 64'(o_dec_ready), 64'd1);
        next_cycle();
        i_dec_valid = 1'b0;
        chk("both_rd_idx1", 64'(o_rf_reg_num_1), 64'd3);
        chk("both_rd_op", 64'(o_rf_op), 64'd0);
        next_cycle();
        chk("both_rd_valid", 64'(o_rd_valid), 64'd1);

        // Write to x0 is discarded; read of x0 returns 0
        i_wb_valid = 1'b1;
        i_wb_rd = 5'd0;
        i_wb_val = 32'hFFFF_FFFF;
        next_cycle();
        i_wb_valid = 1'b0;
        chk("x0_rf_op", 64'(o_rf_op), 64'd0);
        chk("x0_busy", 64'(o_busy_mask), 64'd0);
        i_dec_valid = 1'b1;
        i_dec_rs1 = 5'd0;
        i_dec_rs2 = 5'd10;
        #2;
        chk("x0_dec_ready", 64'(o_dec_ready), 64'd1);
        next_cycle();
        i_dec_valid = 1'b0;
        next_cycle();
        chk("x0_rd_valid", 64'(o_rd_valid), 64'd1);
        chk("x0_rd_rs_1", 64'(o_rd_rs_1), 64'd0);
        chk("x0_rd_rs_2", 64'(o_rd_rs_2), 64'd100);

        // Reset right after a read acceptance
        i_dec_valid = 1'b1;
        i_dec_rs1 = 5'd10;
        i_dec_rs2 = 5'd11;
        i_dec_rd = 5'd9;
        i_dec_set_busy = 1'b1;
        next_cycle();
        i_dec_valid = 1'b0;
        i_dec_set_busy = 1'b0;
        chk("mid_busy9", 64'(o_busy_mask), 64'h200);
        i_rst = 1'b1;
        next_cycle();
        i_rst = 1'b0;
        #2;
        chk("mid_rd_valid", 64'(o_rd_valid), 64'd0);
        chk("mid_busy_clr", 64'(o_busy_mask), 64'd0);
        chk("mid_rf_rst", 64'(o_rf_rst), 64'd1);
        chk("mid_wb_ready", 64'(o_wb_ready), 64'd0);
        next_cycle();
        chk("mid_rd_valid2", 64'(o_rd_valid), 64'd0);
        chk("mid_rf_rst2", 64'(o_rf_rst), 64'd1);
        next_cycle();
        chk("mid_rf_rst_done", 64'(o_rf_rst), 64'd0);
        chk("mid_wb_ready_back", 64'(o_wb_ready), 64'd1);
        chk("mid_rd_valid3", 64'(o_rd_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
